// File: rtl/post_mem_arbiter.sv
// Arbitrates the Post CPU code/data memories between the CPU and the SPI programmer.
// Define POST_ARB_COLLISION_CNT_EN to add the CNT_W parameter and the coll_cnt output.
module post_mem_arbiter #(
    parameter int RESUME_DLY = 4
`ifdef POST_ARB_COLLISION_CNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             prog_mode,
    input  logic             prg_stb,
    input  logic [7:0]       prg_cadd,
    input  logic [3:0]       prg_cwdata,
    input  logic             prg_cwe,
    input  logic [7:0]       prg_dadd,
    input  logic             prg_dwdata,
    input  logic             prg_dwe,
    output logic [3:0]       prg_crdata,
    output logic             prg_drdata,
    input  logic             cpu_req,
    input  logic [7:0]       cpu_cadd,
    input  logic [7:0]       cpu_dadd,
    input  logic             cpu_dwdata,
    input  logic             cpu_dwe,
    output logic             cpu_ack,
    output logic             cpu_rvalid,
    output logic [3:0]       cpu_crdata,
    output logic             cpu_drdata,
    output logic             cpu_halt,
    output logic             cpu_restart,
`ifdef POST_ARB_COLLISION_CNT_EN
    output logic [CNT_W-1:0] coll_cnt,
`endif
    output logic             mem_cen,
    output logic             mem_cwe,
    output logic [7:0]       mem_cadd,
    output logic [3:0]       mem_cwdata,
    input  logic [3:0]       mem_crdata,
    output logic             mem_den,
    output logic             mem_dwe,
    output logic [7:0]       mem_dadd,
    output logic             mem_dwdata,
    input  logic             mem_drdata
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GR_NONE = 2'd0,
        GR_PRG  = 2'd1,
        GR_CPU  = 2'd2
    } grant_t;

    localparam logic [3:0] RESUME_LOAD = 4'(RESUME_DLY - 1);

    state_t     r_state;
    grant_t     r_last_grant;
    logic [3:0] r_resume_cnt;
    logic       r_cpu_halt;
    logic       r_cpu_restart;
    logic [3:0] r_prg_chold;
    logic       r_prg_dhold;
    logic [3:0] r_cpu_chold;
    logic       r_cpu_dhold;
    logic       w_prg_go;
    logic       w_cpu_go;

    // Grants are gated by RST_N so every output reads 0 while reset is held.
    assign w_prg_go = RST_N & prg_stb;
    assign w_cpu_go = RST_N & (r_state == ST_RUN) & cpu_req & ~prg_stb;

    // Memory port mux driven by this cycle's grant.
    always_comb begin
        mem_cen    = 1'b0;
        mem_cwe    = 1'b0;
        mem_cadd   = 8'h00;
        mem_cwdata = 4'h0;
        mem_den    = 1'b0;
        mem_dwe    = 1'b0;
        mem_dadd   = 8'h00;
        mem_dwdata = 1'b0;
        if (w_prg_go) begin
            mem_cen    = 1'b1;
            mem_cwe    = prg_cwe;
            mem_cadd   = prg_cadd;
            mem_cwdata = prg_cwdata;
            mem_den    = 1'b1;
            mem_dwe    = prg_dwe;
            mem_dadd   = prg_dadd;
            mem_dwdata = prg_dwdata;
        end else if (w_cpu_go) begin
            mem_cen    = 1'b1;
            mem_cwe    = 1'b0;
            mem_cadd   = cpu_cadd;
            mem_cwdata = 4'h0;
            mem_den    = 1'b1;
            mem_dwe    = cpu_dwe;
            mem_dadd   = cpu_dadd;
            mem_dwdata = cpu_dwdata;
        end else begin
            mem_cen    = 1'b0;
            mem_den    = 1'b0;
        end
    end

    // Halt/resume handshake; an access acked in the last RUN cycle still completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_RUN;
            r_resume_cnt  <= 4'd0;
            r_cpu_halt    <= 1'b0;
            r_cpu_restart <= 1'b0;
        end else begin
            r_cpu_restart <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (prog_mode) begin
                        r_state    <= ST_HALT;
                        r_cpu_halt <= 1'b1;
                    end else begin
                        r_cpu_halt <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_cpu_halt <= 1'b1;
                    if (!prog_mode) begin
                        r_state      <= ST_RESUME;
                        r_resume_cnt <= RESUME_LOAD;
                    end
                end
                ST_RESUME: begin
                    if (prog_mode) begin
                        r_state <= ST_HALT;
                    end else if (r_resume_cnt == 4'd0) begin
                        r_state       <= ST_RUN;
                        r_cpu_halt    <= 1'b0;
                        r_cpu_restart <= 1'b1;
                    end else begin
                        r_resume_cnt <= r_resume_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_cpu_halt <= 1'b0;
                end
            endcase
        end
    end

    // Remember who owned the memories so next cycle's read data goes to them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_grant <= GR_NONE;
        end else if (w_prg_go) begin
            r_last_grant <= GR_PRG;
        end else if (w_cpu_go) begin
            r_last_grant <= GR_CPU;
        end else begin
            r_last_grant <= GR_NONE;
        end
    end

    // Hold the returned words until the same requester accesses again.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prg_chold <= 4'h0;
            r_prg_dhold <= 1'b0;
            r_cpu_chold <= 4'h0;
            r_cpu_dhold <= 1'b0;
        end else begin
            case (r_last_grant)
                GR_PRG: begin
                    r_prg_chold <= mem_crdata;
                    r_prg_dhold <= mem_drdata;
                end
                GR_CPU: begin
                    r_cpu_chold <= mem_crdata;
                    r_cpu_dhold <= mem_drdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign prg_crdata  = (r_last_grant == GR_PRG) ? mem_crdata : r_prg_chold;
    assign prg_drdata  = (r_last_grant == GR_PRG) ? mem_drdata : r_prg_dhold;
    assign cpu_crdata  = (r_last_grant == GR_CPU) ? mem_crdata : r_cpu_chold;
    assign cpu_drdata  = (r_last_grant == GR_CPU) ? mem_drdata : r_cpu_dhold;
    assign cpu_rvalid  = (r_last_grant == GR_CPU);
    assign cpu_ack     = w_cpu_go;
    assign cpu_halt    = r_cpu_halt;
    assign cpu_restart = r_cpu_restart;

`ifdef POST_ARB_COLLISION_CNT_EN
    logic [CNT_W-1:0] r_coll_cnt;

    // Saturating count of RUN cycles where the CPU lost to the programmer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_coll_cnt <= {CNT_W{1'b0}};
        end else if (prg_stb && cpu_req && (r_state == ST_RUN) && !(&r_coll_cnt)) begin
            r_coll_cnt <= r_coll_cnt + CNT_W'(1);
        end else begin
            r_coll_cnt <= r_coll_cnt;
        end
    end

    assign coll_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_post_mem_arbiter.sv
// Self-checking bench for post_mem_arbiter: vector table, hand sequences and a
// randomized phase checked against a memory-content reference model.
module tb_post_mem_arbiter;
    localparam int RESUME_DLY = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       prog_mode = 1'b0;
    logic       prg_stb = 1'b0;
    logic [7:0] prg_cadd = 8'h00;
    logic [3:0] prg_cwdata = 4'h0;
    logic       prg_cwe = 1'b0;
    logic [7:0] prg_dadd = 8'h00;
    logic       prg_dwdata = 1'b0;
    logic       prg_dwe = 1'b0;
    logic [3:0] prg_crdata;
    logic       prg_drdata;
    logic       cpu_req = 1'b0;
    logic [7:0] cpu_cadd = 8'h00;
    logic [7:0] cpu_dadd = 8'h00;
    logic       cpu_dwdata = 1'b0;
    logic       cpu_dwe = 1'b0;
    logic       cpu_ack, cpu_rvalid, cpu_drdata, cpu_halt, cpu_restart;
    logic [3:0] cpu_crdata;
    logic       mem_cen, mem_cwe, mem_den, mem_dwe, mem_dwdata;
    logic [7:0] mem_cadd, mem_dadd;
    logic [3:0] mem_cwdata;
    logic [3:0] mem_crdata = 4'h0;
    logic       mem_drdata = 1'b0;
`ifdef POST_ARB_COLLISION_CNT_EN
    logic [7:0] coll_cnt;
`endif

    post_mem_arbiter #(
        .RESUME_DLY(RESUME_DLY)
`ifdef POST_ARB_COLLISION_CNT_EN
        , .CNT_W(8)
`endif
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .prog_mode(prog_mode),
        .prg_stb(prg_stb), .prg_cadd(prg_cadd), .prg_cwdata(prg_cwdata), .prg_cwe(prg_cwe),
        .prg_dadd(prg_dadd), .prg_dwdata(prg_dwdata), .prg_dwe(prg_dwe),
        .prg_crdata(prg_crdata), .prg_drdata(prg_drdata),
        .cpu_req(cpu_req), .cpu_cadd(cpu_cadd), .cpu_dadd(cpu_dadd),
        .cpu_dwdata(cpu_dwdata), .cpu_dwe(cpu_dwe),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_crdata(cpu_crdata),
        .cpu_drdata(cpu_drdata), .cpu_halt(cpu_halt), .cpu_restart(cpu_restart),
`ifdef POST_ARB_COLLISION_CNT_EN
        .coll_cnt(coll_cnt),
`endif
        .mem_cen(mem_cen), .mem_cwe(mem_cwe), .mem_cadd(mem_cadd), .mem_cwdata(mem_cwdata),
        .mem_crdata(mem_crdata), .mem_den(mem_den), .mem_dwe(mem_dwe), .mem_dadd(mem_dadd),
        .mem_dwdata(mem_dwdata), .mem_drdata(mem_drdata)
    );

    always #5 CLK = ~CLK;

    // Single-port registered-read memories behind the arbiter.
    logic [3:0] code_mem [256];
    logic       data_mem [256];
    always @(posedge CLK) begin
        if (mem_cen) begin
            if (mem_cwe) code_mem[mem_cadd] <= mem_cwdata;
            mem_crdata <= code_mem[mem_cadd];
        end
        if (mem_den) begin
            if (mem_dwe) data_mem[mem_dadd] <= mem_dwdata;
            mem_drdata <= data_mem[mem_dadd];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: expected memory contents and what each requester should see.
    logic [3:0] m_code [256];
    logic       m_data [256];
    logic       halted_exp = 1'b0, restart_exp = 1'b0, prev_ack = 1'b0, ack_exp = 1'b0;
    logic       pc_known = 1'b1, pd_known = 1'b1, cd_known = 1'b1;
    logic [3:0] exp_pc = 4'h0, exp_cc = 4'h0;
    logic       exp_pd = 1'b0, exp_cd = 1'b0;
    int         m_coll = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        halted_exp = 1'b0; restart_exp = 1'b0; prev_ack = 1'b0;
        pc_known = 1'b1; pd_known = 1'b1; cd_known = 1'b1;
        exp_pc = 4'h0; exp_pd = 1'b0; exp_cc = 4'h0; exp_cd = 1'b0;
        m_coll = 0;
    endtask

    task automatic mid();
        @(negedge CLK);
        ack_exp = cpu_req & ~prg_stb & ~halted_exp;
        chk("cpu_ack", 8'(cpu_ack), 8'(ack_exp));
        chk("cpu_rvalid", 8'(cpu_rvalid), 8'(prev_ack));
        chk("cpu_halt", 8'(cpu_halt), 8'(halted_exp));
        chk("cpu_restart", 8'(cpu_restart), 8'(restart_exp));
        if (prg_stb) begin
            chk("mem_cen", 8'(mem_cen), 8'd1);
            chk("mem_den", 8'(mem_den), 8'd1);
            chk("mem_cwe", 8'(mem_cwe), 8'(prg_cwe));
            chk("mem_dwe", 8'(mem_dwe), 8'(prg_dwe));
            chk("mem_cadd", mem_cadd, prg_cadd);
            chk("mem_dadd", mem_dadd, prg_dadd);
            if (prg_cwe) chk("mem_cwdata", 8'(mem_cwdata), 8'(prg_cwdata));
            if (prg_dwe) chk("mem_dwdata", 8'(mem_dwdata), 8'(prg_dwdata));
        end else if (ack_exp) begin
            chk("mem_cen", 8'(mem_cen), 8'd1);
            chk("mem_den", 8'(mem_den), 8'd1);
            chk("mem_cwe", 8'(mem_cwe), 8'd0);
            chk("mem_dwe", 8'(mem_dwe), 8'(cpu_dwe));
            chk("mem_cadd", mem_cadd, cpu_cadd);
            chk("mem_dadd", mem_dadd, cpu_dadd);
            if (cpu_dwe) chk("mem_dwdata", 8'(mem_dwdata), 8'(cpu_dwdata));
        end else begin
            chk("mem_cen_idle", 8'(mem_cen), 8'd0);
            chk("mem_den_idle", 8'(mem_den), 8'd0);
            chk("mem_cwe_idle", 8'(mem_cwe), 8'd0);
            chk("mem_dwe_idle", 8'(mem_dwe), 8'd0);
        end
        if (pc_known) chk("prg_crdata", 8'(prg_crdata), 8'(exp_pc));
        if (pd_known) chk("prg_drdata", 8'(prg_drdata), 8'(exp_pd));
        chk("cpu_crdata", 8'(cpu_crdata), 8'(exp_cc));
        if (cd_known) chk("cpu_drdata", 8'(cpu_drdata), 8'(exp_cd));
`ifdef POST_ARB_COLLISION_CNT_EN
        chk("coll_cnt", coll_cnt, 8'(m_coll));
`endif
    endtask

    task automatic fin();
        @(posedge CLK);
        if (prg_stb && cpu_req && !halted_exp && m_coll < 255) m_coll++;
        prev_ack = ack_exp;
        if (prg_stb) begin
            pc_known = !prg_cwe; exp_pc = m_code[prg_cadd];
            pd_known = !prg_dwe; exp_pd = m_data[prg_dadd];
            if (prg_cwe) m_code[prg_cadd] = prg_cwdata;
            if (prg_dwe) m_data[prg_dadd] = prg_dwdata;
        end else if (ack_exp) begin
            exp_cc = m_code[cpu_cadd];
            cd_known = !cpu_dwe; exp_cd = m_data[cpu_dadd];
            if (cpu_dwe) m_data[cpu_dadd] = cpu_dwdata;
        end
        #1;
    endtask

    task automatic cycle();
        mid();
        fin();
    endtask

    task automatic drive_prg(input logic stb, input logic cwe, input logic dwe,
                             input logic [7:0] addr, input logic [3:0] wd);
        prg_stb = stb; prg_cwe = cwe; prg_dwe = dwe;
        prg_cadd = addr; prg_dadd = addr; prg_cwdata = wd; prg_dwdata = wd[0];
    endtask

    typedef struct {
        logic       stb, cwe, dwe;
        logic [7:0] padd;
        logic [3:0] pwd;
        logic       req;
        logic [7:0] cadd;
        logic       e_ack, e_cen, e_cwe, e_rvalid;
        logic [7:0] e_cadd;
    } vec_t;
    vec_t tbl [9];

    initial begin
        logic [13:0] pm_v, hx_v, rx_v;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h22, 4'h0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h05, 4'h7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h30, 4'h9, 1'b1, 8'h31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h30};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h31, 1'b1, 1'b1, 1'b0, 1'b0, 8'h31};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h05, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h22, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};

        // Power-on reset: every output must be zero.
        #12;
        chk("rst_cpu_halt", 8'(cpu_halt), 8'd0);
        chk("rst_cpu_ack", 8'(cpu_ack), 8'd0);
        chk("rst_mem_cen", 8'(mem_cen), 8'd0);
        chk("rst_prg_crdata", 8'(prg_crdata), 8'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        reset_model();

        // Fill both memories with simultaneous code+data writes; 0x22 gets 0xA / 1.
        for (int a = 0; a < 256; a++) begin
            drive_prg(1'b1, 1'b1, 1'b1, 8'(a), (a == 8'h22) ? 4'hA : 4'($urandom));
            if (a == 8'h22) prg_dwdata = 1'b1;
            cycle();
        end
        drive_prg(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

        for (int i = 0; i < 9; i++) begin
            drive_prg(tbl[i].stb, tbl[i].cwe, tbl[i].dwe, tbl[i].padd, tbl[i].pwd);
            cpu_req = tbl[i].req; cpu_cadd = tbl[i].cadd; cpu_dadd = tbl[i].cadd; cpu_dwe = 1'b0;
            mid();
            chk("tbl_ack", 8'(cpu_ack), 8'(tbl[i].e_ack));
            chk("tbl_cen", 8'(mem_cen), 8'(tbl[i].e_cen));
            chk("tbl_cwe", 8'(mem_cwe), 8'(tbl[i].e_cwe));
            chk("tbl_rvalid", 8'(cpu_rvalid), 8'(tbl[i].e_rvalid));
            if (tbl[i].e_cen) chk("tbl_cadd", mem_cadd, tbl[i].e_cadd);
            fin();
        end
        drive_prg(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        cpu_req = 1'b0;

        // Programmer read data must survive idle cycles and CPU traffic.
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'b1; cpu_cadd = 8'($urandom); cpu_dadd = 8'($urandom);
            cycle();
            cpu_req = 1'b0;
            cycle();
        end
        chk("prg_crdata_held", 8'(prg_crdata), 8'h0A);
        chk("prg_drdata_held", 8'(prg_drdata), 8'h01);

        // Halt, partial resume interrupted by prog_mode, full resume, restart pulse.
        pm_v = 14'b00000001100111;
        hx_v = 14'b00111111111110;
        rx_v = 14'b01000000000000;
        cpu_req = 1'b1; cpu_cadd = 8'h05; cpu_dadd = 8'h30; cpu_dwe = 1'b0;
        for (int c = 0; c < 14; c++) begin
            prog_mode = pm_v[c]; halted_exp = hx_v[c]; restart_exp = rx_v[c];
            drive_prg(c == 2 || c == 9, c == 2, 1'b0, 8'h40, 4'h3);
            cycle();
        end
        prog_mode = 1'b0; halted_exp = 1'b0; restart_exp = 1'b0; cpu_req = 1'b0;
        drive_prg(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

        // Random traffic in RUN over a small address window.
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req || prev_ack) begin
                cpu_req = 1'($urandom_range(0, 1));
                cpu_cadd = 8'($urandom_range(0, 15)); cpu_dadd = 8'($urandom_range(0, 15));
                cpu_dwe = 1'($urandom_range(0, 1)); cpu_dwdata = 1'($urandom_range(0, 1));
            end
            drive_prg($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 15)), 4'($urandom));
            cycle();
        end

        // Long collision run drives the counter into saturation.
        cpu_req = 1'b1; cpu_dwe = 1'b0;
        for (int n = 0; n < 300; n++) begin
            drive_prg(1'b1, 1'b0, 1'b0, 8'($urandom), 4'h0);
            cycle();
        end
        drive_prg(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        cycle();
`ifdef POST_ARB_COLLISION_CNT_EN
        chk("coll_cnt_sat", coll_cnt, 8'hFF);
`endif

        // Asynchronous reset in the middle of HALT.
        prog_mode = 1'b1;
        cycle();
        halted_exp = 1'b1;
        cycle();
        cycle();
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst_cpu_halt", 8'(cpu_halt), 8'd0);
        chk("arst_cpu_ack", 8'(cpu_ack), 8'd0);
        chk("arst_cpu_rvalid", 8'(cpu_rvalid), 8'd0);
        chk("arst_cpu_restart", 8'(cpu_restart), 8'd0);
        chk("arst_mem_cen", 8'(mem_cen), 8'd0);
        chk("arst_mem_den", 8'(mem_den), 8'd0);
        chk("arst_mem_cadd", mem_cadd, 8'd0);
        chk("arst_prg_crdata", 8'(prg_crdata), 8'd0);
        chk("arst_cpu_crdata", 8'(cpu_crdata), 8'd0);
`ifdef POST_ARB_COLLISION_CNT_EN
        chk("arst_coll_cnt", coll_cnt, 8'd0);
`endif
        prog_mode = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        reset_model();
        for (int n = 0; n < 50; n++) begin
            if (!cpu_req || prev_ack) begin
                cpu_req = 1'($urandom_range(0, 1));
                cpu_cadd = 8'($urandom_range(0, 15)); cpu_dadd = 8'($urandom_range(0, 15));
                cpu_dwe = 1'($urandom_range(0, 1)); cpu_dwdata = 1'($urandom_range(0, 1));
            end
            drive_prg($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 15)), 4'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/post_mem_arbiter.md
Name: post_mem_arbiter

Overview:
- Shares the Post CPU code memory (256 x 4 bit) and data memory (256 x 1 bit) between two requesters: the running CPU and the SPI programming slave.
- Sits between slave_spi4post (programmer side), the CPU core and the two single-port, registered-read memories.
- Programmer accesses always win.
- A programming-mode handshake halts the CPU while memories are rewritten, then restarts it cleanly.

Parameters:
- RESUME_DLY, 4, cycles cpu_halt stays high after prog_mode falls (1..15).
- CNT_W, 8, width of the optional collision counter.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- prog_mode  in  1  level; 1 = programming session, halt the CPU.
- prg_stb  in  1  one-cycle programmer access strobe (slave prog_clk); address/data/we stable this cycle.
- prg_cadd  in  8  programmer code address.
- prg_cwdata  in  4  programmer code write data.
- prg_cwe  in  1  programmer code write enable.
- prg_dadd  in  8  programmer data address.
- prg_dwdata  in  1  programmer data write data.
- prg_dwe  in  1  programmer data write enable.
- prg_crdata  out  4  code read data to programmer (slave cin_prg).
- prg_drdata  out  1  data read data to programmer (slave din_prg).
- cpu_req  in  1  level request; held with address/data until cpu_ack.
- cpu_cadd  in  8  CPU code (fetch) address.
- cpu_dadd  in  8  CPU data address.
- cpu_dwdata  in  1  CPU data write data.
- cpu_dwe  in  1  CPU data write enable.
- cpu_ack  out  1  one-cycle pulse: CPU access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse, cycle after cpu_ack.
- cpu_crdata  out  4  fetched code word.
- cpu_drdata  out  1  data read value.
- cpu_halt  out  1  CPU must freeze.
- cpu_restart  out  1  one-cycle pulse: CPU resets its PC to 0.
- mem_cen / mem_cwe  out  1 each  code memory enable / write enable.
- mem_cadd  out  8  code memory address.
- mem_cwdata  out  4  code memory write data.
- mem_crdata  in  4  code memory read data, valid cycle after mem_cen.
- mem_den / mem_dwe  out  1 each  data memory enable / write enable.
- mem_dadd  out  8  data memory address.
- mem_dwdata  out  1  data memory write data.
- mem_drdata  in  1  data memory read data, valid cycle after mem_den.

Behaviour:
- Reset (RST_N low, async): state RUN, all outputs 0, hold registers 0, resume counter 0.
- Memory side is combinational from the current cycle's grant.
  - prg_stb=1: mem_cen=mem_den=1, programmer addr/data/we muxed through.
  - Else if CPU granted: mem_cen=mem_den=1, mem_cwe=0, CPU signals muxed through.
  - Else all enables 0.
- Registered last-grant flag (PRG/CPU/NONE) routes the next-cycle read data.
  - prg_crdata/prg_drdata = mem rdata in the cycle after a prg access; hold registers capture it and drive these outputs until the next prg access.
  - Write accesses also return the read port value, which is don't-care.
  - cpu_crdata/cpu_drdata behave the same way on the CPU side, with cpu_rvalid=1 that cycle.
- FSM states:
  - RUN:
    - cpu_ack = cpu_req & ~prg_stb.
    - prg_stb together with cpu_req defers the CPU one cycle; its request stays pending.
    - prog_mode=1 -> HALT next cycle, even if cpu_req was acked this cycle; that access completes normally.
  - HALT:
    - cpu_halt=1, cpu_ack=0, only prg accesses.
    - prog_mode=0 -> RESUME with counter loaded to RESUME_DLY-1.
  - RESUME:
    - cpu_halt=1, prg accesses still serviced.
    - Counter decrements each cycle. prog_mode=1 -> back to HALT.
    - At counter 0 -> RUN; cpu_restart=1 and cpu_halt=0 in the first RUN cycle.
- cpu_halt rises the cycle after prog_mode is sampled high, a 1-cycle latency.
- prg access latency is 1 cycle. Back-to-back prg_stb on consecutive cycles is legal and pipelines.
- Writes with prg_cwe and prg_dwe both set update both memories in the same cycle.

Optional Feature:
- Macro POST_ARB_COLLISION_CNT_EN.
- When defined, adds output port coll_cnt [CNT_W-1:0]: counts cycles with prg_stb & cpu_req & state RUN.
  - Saturates at all-ones; cleared only by reset.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive RST_N low mid-HALT -> all outputs 0, state RUN, cpu_halt=0 immediately and asynchronously.
- Collision: cpu_req=1, cpu_cadd=0x10 while prg_stb=1, prg_cadd=0x22 -> mem_cadd=0x22, cpu_ack=0. Next cycle mem_cadd=0x10, cpu_ack=1; following cycle cpu_rvalid=1.
- Programmer read: preload code[0x22]=0xA, data[0x22]=1, then prg_stb read at 0x22 -> prg_crdata=0xA, prg_drdata=1 from the cycle after the strobe. Both stay held through 10 idle cycles and through CPU accesses.
- Programmer write: prg_stb, prg_cwe=1, prg_cadd=0x05, prg_cwdata=0x7 -> mem_cwe=1 that cycle. A later CPU fetch at 0x05 returns cpu_crdata=0x7.
- Halt/resume with RESUME_DLY=4: prog_mode 0->1 -> cpu_halt=1 next cycle, and cpu_req is not acked. prog_mode->0 -> cpu_halt stays high 4 more cycles, then cpu_restart pulses exactly 1 cycle.
- With POST_ARB_COLLISION_CNT_EN and CNT_W=8: 300 collision cycles -> coll_cnt=0xFF. Collisions while in HALT are not counted.
